// File: rtl/pht_access_arbiter_if.sv
// pht_access_arbiter_if
//   Bundles the fetch lookup, execute update and table-port signals of the
//   pattern-history-table arbiter.
//   slave  : arbiter side (consumes requests, owns the table port)
//   master : environment side (fetch, execute, table storage)
interface pht_access_arbiter_if #(
  parameter int INDEX_WIDTH = 6
);
  logic                   lookupReq;
  logic [INDEX_WIDTH-1:0] lookupIndex;
  logic                   lookupGrant;
  logic                   lookupValid;
  logic                   lookupTaken;
  logic                   updateValid;
  logic [INDEX_WIDTH-1:0] updateIndex;
  logic                   updateTaken;
  logic                   updateReady;
  logic                   tableWe;
  logic [INDEX_WIDTH-1:0] tableAddr;
  logic [1:0]             tableWdata;
  logic [1:0]             tableRdata;

  modport slave (
    input  lookupReq, lookupIndex, updateValid, updateIndex, updateTaken, tableRdata,
    output lookupGrant, lookupValid, lookupTaken, updateReady, tableWe, tableAddr, tableWdata
  );

  modport master (
    output lookupReq, lookupIndex, updateValid, updateIndex, updateTaken, tableRdata,
    input  lookupGrant, lookupValid, lookupTaken, updateReady, tableWe, tableAddr, tableWdata
  );
endinterface

// File: rtl/pht_access_arbiter.sv
// pht_access_arbiter
//   Owns the single port of a 2-bit-counter pattern history table and shares
//   it between fetch lookups and read-modify-write updates from execute.
//   After reset the whole table is swept to weak-not-taken (01). Resolved
//   branches wait in a small FIFO; an update takes two cycles (read, then
//   write of the saturated counter). Lookups win unless the queue is full or
//   lookups have been granted STARVE_LIMIT times in a row with work pending.
// Ports
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : pht_access_arbiter_if.slave (lookup, update and table signals)
module pht_access_arbiter #(
  parameter int INDEX_WIDTH  = 6,
  parameter int QUEUE_DEPTH  = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  pht_access_arbiter_if.slave   bus
);

  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_WRITE} state_t;

  typedef struct packed {
    logic [INDEX_WIDTH-1:0] idx;
    logic                   taken;
  } upd_t;

  state_t                 r_state, w_state_nxt;
  logic [INDEX_WIDTH-1:0] r_init_cnt;
  upd_t                   r_q [QUEUE_DEPTH];
  logic [PW-1:0]          r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]          r_count;
  logic [SW-1:0]          r_starve;
  logic                   r_lookup_valid;

  logic                   w_empty, w_full, w_push, w_pop;
  logic                   w_sel_upd, w_want_upd;
  logic                   w_we, w_grant;
  logic [INDEX_WIDTH-1:0] w_addr;
  logic [1:0]             w_wdata, w_sat;
  upd_t                   w_head;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(QUEUE_DEPTH));
  assign w_head  = r_q[r_rd_ptr];
  assign w_push  = bus.updateValid & ~w_full;

  // Updates bypass pending lookups when the queue is full or lookups have
  // been favoured long enough.
  assign w_want_upd = ~w_empty &
                      (~bus.lookupReq | w_full | (r_starve == SW'(STARVE_LIMIT)));

  // 2-bit saturating counter step for the queue head.
  always_comb begin
    w_sat = bus.tableRdata;
    if (w_head.taken) begin
      if (bus.tableRdata != 2'b11) w_sat = bus.tableRdata + 2'b01;
    end else begin
      if (bus.tableRdata != 2'b00) w_sat = bus.tableRdata - 2'b01;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_addr      = bus.lookupIndex;
    w_wdata     = 2'b00;
    w_grant     = 1'b0;
    w_pop       = 1'b0;
    w_sel_upd   = 1'b0;
    case (r_state)
      S_INIT: begin
        w_we    = 1'b1;
        w_addr  = r_init_cnt;
        w_wdata = 2'b01;
        if (r_init_cnt == '1) w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (w_want_upd) begin
          w_sel_upd   = 1'b1;
          w_addr      = w_head.idx;
          w_state_nxt = S_WRITE;
        end else if (bus.lookupReq) begin
          w_grant = 1'b1;
        end
      end
      S_WRITE: begin
        w_we        = 1'b1;
        w_addr      = w_head.idx;
        w_wdata     = w_sat;
        w_pop       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  // Outputs are forced quiet while reset is held, independent of state.
  assign bus.tableWe     = rst & w_we;
  assign bus.tableAddr   = rst ? w_addr  : '0;
  assign bus.tableWdata  = rst ? w_wdata : 2'b00;
  assign bus.lookupGrant = rst & w_grant;
  assign bus.updateReady = ~rst | ~w_full;
  assign bus.lookupValid = r_lookup_valid;
  assign bus.lookupTaken = r_lookup_valid & bus.tableRdata[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_INIT;
      r_init_cnt     <= '0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_starve       <= '0;
      r_lookup_valid <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_lookup_valid <= w_grant;
      if (r_state == S_INIT) r_init_cnt <= r_init_cnt + 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_empty || w_sel_upd)
        r_starve <= '0;
      else if (w_grant && (r_starve != SW'(STARVE_LIMIT)))
        r_starve <= r_starve + 1'b1;
    end
  end

  // Queue storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_q[r_wr_ptr] <= '{idx: bus.updateIndex, taken: bus.updateTaken};
  end

endmodule

// File: doc/pht_access_arbiter.md
PHT_ACCESS_ARBITER -- requirements
Module: pht_access_arbiter

Interface
REQ-001 SHALL take parameter INDEX_WIDTH, default 6, as the pattern-history-table index width (2^INDEX_WIDTH entries).
REQ-002 SHALL take parameter QUEUE_DEPTH, default 4, as the update queue depth (power of two, >=2).
REQ-003 SHALL take parameter STARVE_LIMIT, default 3, as the maximum consecutive lookup grants while updates are pending.
REQ-004 SHALL have one clock; reset is asynchronous and active-low (ports clk, rst).
REQ-005 clk  in  1  clock, all state on rising edge.
REQ-006 rst  in  1  asynchronous active-low reset.
REQ-007 lookupReq  in  1  fetch requests a prediction this cycle.
REQ-008 lookupIndex  in  INDEX_WIDTH  table index for the lookup.
REQ-009 lookupGrant  out  1  lookup issued to the table this cycle.
REQ-010 lookupValid  out  1  prediction result valid (cycle after grant).
REQ-011 lookupTaken  out  1  predicted taken, meaningful when lookupValid=1.
REQ-012 updateValid  in  1  execute offers a resolved branch.
REQ-013 updateIndex  in  INDEX_WIDTH  table index of the resolved branch.
REQ-014 updateTaken  in  1  resolved direction, 1=taken.
REQ-015 updateReady  out  1  queue can accept an update.
REQ-016 tableWe / tableAddr / tableWdata  out  1 / INDEX_WIDTH / 2  single-port table write enable, address, write data.
REQ-017 tableRdata  in  2  table read data, valid one cycle after a read (tableWe=0) is presented.

Function
REQ-018 SHALL own the single table port and share it between fetch lookups and read-modify-write updates; exactly one access per cycle.
REQ-019 Counter encoding SHALL be 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; prediction = counter bit 1.
REQ-020 Update arithmetic SHALL be 2-bit saturating: taken increments (11 stays 11), not-taken decrements (00 stays 00).
REQ-021 Update queue SHALL be FIFO of {index,taken}; push when updateValid&&updateReady; updateReady = (count != QUEUE_DEPTH); producer holds offer until accepted.
REQ-022 FSM states SHALL be INIT, IDLE, WRITE.
REQ-023 INIT: write 01 to entry initCnt each cycle (tableWe=1), initCnt 0..2^INDEX_WIDTH-1, then IDLE; lookupGrant=0; pushes accepted.
REQ-024 IDLE, update selected: present read of queue head (tableWe=0, tableAddr=head index), lookupGrant=0, next WRITE.
REQ-025 Update selected in IDLE iff queue non-empty and (lookupReq=0 or queue full or starveCnt==STARVE_LIMIT).
REQ-026 IDLE otherwise: if lookupReq=1 present read of lookupIndex, lookupGrant=1; stay IDLE.
REQ-027 WRITE: tableWe=1, tableAddr=head index, tableWdata=saturated update of tableRdata; pop head; lookupGrant=0; next IDLE.
REQ-028 starveCnt SHALL increment on each lookup grant while queue non-empty, clear when an update is selected or queue empty, never exceed STARVE_LIMIT.
REQ-029 lookupValid SHALL be lookupGrant registered; lookupTaken = lookupValid & tableRdata[1].
REQ-030 Push and pop in same cycle SHALL leave count unchanged; push when full is not accepted (updateReady=0).
REQ-031 Lookup of an index with a queued update SHALL return the table value (no forwarding).
REQ-032 Pointers SHALL wrap modulo QUEUE_DEPTH.

Reset
REQ-033 rst=0 SHALL immediately force state INIT, initCnt 0, queue empty, starveCnt 0, lookupValid 0.
REQ-034 While rst=0: lookupGrant=0, lookupValid=0, lookupTaken=0, tableWe=0, tableAddr=0, tableWdata=0, updateReady=1.
REQ-035 Reset asserted mid-INIT or mid-WRITE SHALL abandon the operation; the sweep restarts at entry 0 after release.

Verification
REQ-036 Release reset, INDEX_WIDTH=6 -> 64 INIT cycles writing 01 to addresses 0..63, no lookupGrant until cycle 65.
REQ-037 Idle, push {5,taken} -> read addr 5, next cycle write 10 (rdata 01); rdata 11 -> writes 11; not-taken with rdata 00 -> writes 00.
REQ-038 lookupReq held high, one update queued -> 3 grants, then 2-cycle update, then grants resume.
REQ-039 Push 4 updates with lookupReq high -> updateReady=0 on 5th offer; update forced immediately; updateReady returns after WRITE.
REQ-040 Lookup index 7 granted with rdata 10 -> lookupValid=1, lookupTaken=1 next cycle.
REQ-041 Assert rst during WRITE -> tableWe drops same cycle, queue empty, INIT restarts at 0 after release.
